// File: rtl/conv_pkg.sv
// Shared widths, types and sizing helper for the conv window producer.
package conv_pkg;

  localparam int PIX_W = 9;
  localparam int K     = 5;
  localparam int COL_W = K * PIX_W;
  localparam int LB_W  = (K - 1) * PIX_W;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef logic [COL_W-1:0]        col_t;

  typedef enum logic {
    PH_STOP,
    PH_RUN
  } ph_state_t;

  // Minimum 1 so single-valued counters still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_col_buf.sv
// Per-column store of the four previous image rows; the oldest row sits in the top bits.
module conv_col_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [LB_W-1:0] wdata,
  output logic [LB_W-1:0] rdata
);

  logic [LB_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Producer end of the conv window interface: builds 5x5 windows and paces them to the consumer loop.
// Optional macro CONV_WIN_POS_EN adds win_row/win_col (top-left coordinate of each emitted window).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int CONV_CYC = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_start,
  output logic             x_valid,
  output logic [COL_W-1:0] x_m_1,
  output logic [COL_W-1:0] x_m_2,
  output logic [COL_W-1:0] x_m_3,
  output logic [COL_W-1:0] x_m_4,
  output logic [COL_W-1:0] x_m_5,
  output logic             frame_done
`ifdef CONV_WIN_POS_EN
  ,
  output logic [7:0]       win_row,
  output logic [7:0]       win_col
`endif
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam int PW = clog2(CONV_CYC);

  logic [CW-1:0]   col_q, eff_col;
  logic [RW-1:0]   row_q, eff_row;
  logic [LB_W-1:0] lb_rd;
  col_t            new_col;
  col_t            win_q [K];
  logic            accept, win_cmp, last_pix, pending_q, emit;
  ph_state_t       ph_state, ph_next;
  logic [PW-1:0]   phase_q, phase_d;

  assign accept   = pix_valid && pix_ready;
  assign eff_col  = frame_start ? '0 : col_q;
  assign eff_row  = frame_start ? '0 : row_q;
  assign new_col  = {lb_rd, pix_data};
  assign win_cmp  = accept && (eff_row >= RW'(K - 1)) && (eff_col >= CW'(K - 1));
  assign last_pix = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));

  conv_col_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_col_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (eff_col),
    .wdata (new_col[LB_W-1:0]),
    .rdata (lb_rd)
  );

  // The phase loop stays stopped until the first emission, then free-runs until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_state <= PH_STOP;
      phase_q  <= '0;
    end else begin
      ph_state <= ph_next;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    ph_next = ph_state;
    phase_d = phase_q;
    emit    = 1'b0;
    case (ph_state)
      PH_STOP: begin
        if (pending_q) begin
          emit    = 1'b1;
          ph_next = PH_RUN;
          phase_d = '0;
        end
      end
      PH_RUN: begin
        phase_d = (phase_q == PW'(CONV_CYC - 1)) ? '0 : phase_q + PW'(1);
        emit    = pending_q && (phase_q == PW'(CONV_CYC - 1));
      end
      default: ph_next = PH_STOP;
    endcase
  end

  // While a completed window waits for its slot, pix_ready is low so the window stays frozen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q      <= '0;
      col_q      <= '0;
      pending_q  <= 1'b0;
      pix_ready  <= 1'b0;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      x_m_1      <= '0;
      x_m_2      <= '0;
      x_m_3      <= '0;
      x_m_4      <= '0;
      x_m_5      <= '0;
      for (int i = 0; i < K; i++) win_q[i] <= '0;
    end else begin
      x_valid    <= emit;
      frame_done <= accept && last_pix;
      pending_q  <= win_cmp ? 1'b1 : (emit ? 1'b0 : pending_q);
      pix_ready  <= !(win_cmp || (pending_q && !emit));
      if (accept) begin
        if (eff_col == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
        end else begin
          col_q <= eff_col + CW'(1);
          row_q <= eff_row;
        end
        for (int i = 0; i < K - 1; i++) win_q[i] <= win_q[i+1];
        win_q[K-1] <= new_col;
      end
      if (emit) begin
        x_m_1 <= win_q[0];
        x_m_2 <= win_q[1];
        x_m_3 <= win_q[2];
        x_m_4 <= win_q[3];
        x_m_5 <= win_q[4];
      end
    end
  end

`ifdef CONV_WIN_POS_EN
  logic [7:0] pos_row_q, pos_col_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_row_q <= '0;
      pos_col_q <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      if (win_cmp) begin
        pos_row_q <= 8'(eff_row) - 8'(K - 1);
        pos_col_q <= 8'(eff_col) - 8'(K - 1);
      end
      if (emit) begin
        win_row <= pos_row_q;
        win_col <= pos_col_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8 image: window contents, pacing, frame_done, frame_start and reset.
module tb_conv_window_gen;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int CYC  = 5;
  localparam int NWIN = (H - 4) * (W - 4);

  typedef logic [224:0] val_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [8:0]  pix_data = '0;
  logic        pix_ready, x_valid, frame_done;
  logic [44:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
`ifdef CONV_WIN_POS_EN
  logic [7:0]  win_row, win_col;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   win_total = 0;
  int   win_n = 0;
  int   last_xv = -1;
  int   cur_mode = 0;
  bit   cont_mode = 1'b0;
  bit   rnd_valid = 1'b0;
  val_t hold = '0;
  val_t exp_w;

  conv_window_gen #(
    .IMG_W    (W),
    .IMG_H    (H),
    .CONV_CYC (CYC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .x_valid     (x_valid),
    .x_m_1       (x_m_1),
    .x_m_2       (x_m_2),
    .x_m_3       (x_m_3),
    .x_m_4       (x_m_4),
    .x_m_5       (x_m_5),
    .frame_done  (frame_done)
`ifdef CONV_WIN_POS_EN
    ,
    .win_row     (win_row),
    .win_col     (win_col)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input val_t got, input val_t expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [8:0] pixVal(input int mode, input int r, input int c);
    return (mode == 1) ? 9'h100 : 9'(r * W + c);
  endfunction

  // Leftmost column in the top bits; within a column the oldest row comes first.
  function automatic val_t expWin(input int mode, input int n);
    val_t w;
    int   wr, wc;
    w  = '0;
    wr = n / (W - 4);
    wc = n % (W - 4);
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 5; k++)
        w = {w[215:0], pixVal(mode, wr + k, wc + j)};
    return w;
  endfunction

  // Window scoreboard: contents at each x_valid, hold between pulses, pulse spacing.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      win_n   = 0;
      last_xv = -1;
      hold    = '0;
    end else if (x_valid) begin
      exp_w = expWin(cur_mode, win_n);
      checkOutput("x_m_1", val_t'(x_m_1), val_t'(exp_w[224:180]));
      checkOutput("x_m_2", val_t'(x_m_2), val_t'(exp_w[179:135]));
      checkOutput("x_m_3", val_t'(x_m_3), val_t'(exp_w[134:90]));
      checkOutput("x_m_4", val_t'(x_m_4), val_t'(exp_w[89:45]));
      checkOutput("x_m_5", val_t'(x_m_5), val_t'(exp_w[44:0]));
`ifdef CONV_WIN_POS_EN
      checkOutput("win_row", val_t'(win_row), val_t'(win_n / (W - 4)));
      checkOutput("win_col", val_t'(win_col), val_t'(win_n % (W - 4)));
`endif
      if (last_xv >= 0) begin
        checkOutput("xv_gap_mod", val_t'((cyc - last_xv) % CYC), val_t'(0));
        if (cont_mode && (win_n % (W - 4)) != 0)
          checkOutput("xv_gap", val_t'(cyc - last_xv), val_t'(CYC));
      end
      last_xv = cyc;
      hold    = exp_w;
      win_n   = (win_n == NWIN - 1) ? 0 : win_n + 1;
      win_total++;
    end else begin
      checkOutput("x_m_hold", val_t'({x_m_1, x_m_2, x_m_3, x_m_4, x_m_5}), hold);
    end
  end

  // Offers one pixel from a negedge and returns on the negedge after it was accepted.
  task automatic applyStimulus(input logic [8:0] d, input logic fs);
    int guard;
    if (rnd_valid && $urandom_range(0, 1) == 1) @(negedge clk);
    pix_valid   = 1'b1;
    pix_data    = d;
    frame_start = fs;
    guard       = 0;
    while (!pix_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!pix_ready) checkOutput("accept_timeout", val_t'(pix_ready), val_t'(1));
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic sendFrame(input int mode, input bit fs_first, input bit chk_first,
                           input int npix, input int stop_win, input bit chk_count);
    int base;
    base     = win_total;
    cur_mode = mode;
    for (int i = 0; i < npix; i++) begin
      applyStimulus(pixVal(mode, i / W, i % W), (i == 0) && fs_first);
      if (chk_first && i == 4 * W + 4) begin
        checkOutput("first_emit_early", val_t'(x_valid), val_t'(0));
        @(negedge clk);
        checkOutput("first_emit", val_t'(x_valid), val_t'(1));
      end
      if (npix == W * H && i == W * H - 2)
        checkOutput("frame_done_early", val_t'(frame_done), val_t'(0));
      if (npix == W * H && i == W * H - 1)
        checkOutput("frame_done", val_t'(frame_done), val_t'(1));
      if (stop_win > 0 && (win_total - base) >= stop_win) break;
    end
    if (chk_count) begin
      repeat (4 * CYC) @(negedge clk);
      checkOutput("win_count", val_t'(win_total - base), val_t'(NWIN));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pix_ready"}, val_t'(pix_ready), val_t'(0));
    checkOutput({tag, "_x_valid"}, val_t'(x_valid), val_t'(0));
    checkOutput({tag, "_frame_done"}, val_t'(frame_done), val_t'(0));
    checkOutput({tag, "_x_m"}, val_t'({x_m_1, x_m_2, x_m_3, x_m_4, x_m_5}), val_t'(0));
`ifdef CONV_WIN_POS_EN
    checkOutput({tag, "_win_pos"}, val_t'({win_row, win_col}), val_t'(0));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkResetState("rst");
    #2 rstn = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", val_t'(pix_ready), val_t'(1));

    $display("[TB] ramp frame, continuous valid");
    cont_mode = 1'b1;
    rnd_valid = 1'b0;
    sendFrame(0, 1'b0, 1'b1, W * H, 0, 1'b1);

    $display("[TB] constant -256 frame");
    sendFrame(1, 1'b0, 1'b0, W * H, 0, 1'b1);

    $display("[TB] ramp frame, random valid");
    cont_mode = 1'b0;
    rnd_valid = 1'b1;
    sendFrame(0, 1'b0, 1'b0, W * H, 0, 1'b1);

    $display("[TB] frame_start restart after 19 pixels");
    cont_mode = 1'b1;
    rnd_valid = 1'b0;
    sendFrame(0, 1'b0, 1'b0, 19, 0, 1'b0);
    sendFrame(0, 1'b1, 1'b0, W * H, 0, 1'b1);

    $display("[TB] reset mid-frame");
    sendFrame(0, 1'b0, 1'b0, W * H, 7, 1'b0);
    #2 rstn = 1'b0;
    #1 checkResetState("midrst");
    @(negedge clk);
    checkResetState("midrst_hold");
    #2 rstn = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_midrst", val_t'(pix_ready), val_t'(1));
    sendFrame(0, 1'b0, 1'b1, W * H, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
